cpu_run_sequencer: RTL

//  Run-control sequencer for the 8-bit accumulator CPU. Splits each instruction into a FETCH

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/cpu_run_sequencer.sv | 114 +++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: state encoding, halt opcode and bus widths.
// Also imported by the opcode controller, so keep the encoding stable.
package cpu_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    localparam logic [3:0] OPC_HALT = 4'b1111;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_FETCH  = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_HALTED = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_LOAD   = ST_LOAD,
        S_FETCH  = ST_FETCH,
        S_EXEC   = ST_EXEC,
        S_HALTED = ST_HALTED
    } run_state_e;

endpackage

// File: rtl/cpu_run_sequencer.sv
// Run-control sequencer: FETCH/EXEC enables, RUN/STEP/STOP handling, HALT detection
// and program-memory arbitration between the CPU and the external loader.
//
//  state  | meaning
//  IDLE   | waiting for load, run or step request
//  LOAD   | loader owns program memory
//  FETCH  | one-cycle FetchEn (LoadIR/IncPC)
//  EXEC   | one-cycle ExecEn; retire, halt, or stop decision
//  HALTED | HALT retired; only load_req or reset leaves
module cpu_run_sequencer
    import cpu_pkg::*;
#(
    parameter int         ADDR_W   = ADDR_W_DEF,
    parameter int         DATA_W   = DATA_W_DEF,
    parameter int         CNT_W    = 16,
    parameter logic [3:0] HALT_OPC = OPC_HALT
) (
    input  logic              CLK,
    input  logic              CLB,
    input  logic              run_req,
    input  logic              step_req,
    input  logic              stop_req,
    input  logic [3:0]        Opcode,
    input  logic              load_req,
    input  logic              load_valid,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              MemSel,
    output logic              MemWE,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    output logic              FetchEn,
    output logic              ExecEn,
    output logic              Busy,
    output logic              Halted,
    output logic [CNT_W-1:0]  InstrCount
);

    run_state_e       state_q, state_d;
    logic             step_q,  step_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    always_ff @(posedge CLK or negedge CLB) begin
        if (!CLB) begin
            state_q <= S_IDLE;
            step_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        cnt_d      = cnt_q;
        load_ready = 1'b0;
        MemSel     = 1'b0;
        FetchEn    = 1'b0;
        ExecEn     = 1'b0;
        Busy       = 1'b0;
        Halted     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (load_req) begin
                    state_d = S_LOAD;
                end else if (run_req) begin
                    state_d = S_FETCH;
                    step_d  = 1'b0;
                end else if (step_req) begin
                    state_d = S_FETCH;
                    step_d  = 1'b1;
                end
            end
            S_LOAD: begin
                load_ready = 1'b1;
                MemSel     = 1'b1;
                if (!load_req) state_d = S_IDLE;
            end
            S_FETCH: begin
                FetchEn = 1'b1;
                Busy    = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                ExecEn = 1'b1;
                Busy   = 1'b1;
                if (Opcode == HALT_OPC) begin
                    state_d = S_HALTED;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = (step_q || stop_req) ? S_IDLE : S_FETCH;
                end
            end
            S_HALTED: begin
                Halted = 1'b1;
                if (load_req) state_d = S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase

        // The loader's write path is a pure mux so reset removes MemWE without a clock.
        MemWE    = MemSel & load_valid;
        MemAddr  = MemSel ? load_addr : '0;
        MemWData = MemSel ? load_data : '0;
    end

    assign InstrCount = cnt_q;

endmodule
